// File: rtl/psq_shutdown_sequencer.sv
// psq_shutdown_sequencer
// Safety shutdown sequencer: debounces the protection-core trip, fires the
// MGI valve for a fixed window, runs a timed current ramp-down, then holds a
// latched lockout until the operator acknowledges with the trip cleared.
// All outputs are registered decodes of the next state, so every output moves
// on the same edge as the state register and nothing depends combinationally
// on an input.
module psq_shutdown_sequencer #(
  parameter int unsigned DEBOUNCE    = 3,   // 2..255
  parameter int unsigned MGI_CYCLES  = 16,  // 1..65535
  parameter int unsigned RAMP_CYCLES = 64   // 1..65535
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_arm_req,
  input  logic       i_trip_in,
  input  logic       i_force_trip,
  input  logic       i_ack,
  output logic       o_armed,
  output logic       o_mgi_fire,
  output logic       o_ramp_down,
  output logic       o_fault_latched,
  output logic [2:0] o_state,
  output logic [7:0] o_trip_count
);

  localparam logic [2:0] S_SAFE    = 3'd0;
  localparam logic [2:0] S_ARMED   = 3'd1;
  localparam logic [2:0] S_QUALIFY = 3'd2;
  localparam logic [2:0] S_FIRE    = 3'd3;
  localparam logic [2:0] S_RAMP    = 3'd4;
  localparam logic [2:0] S_LOCKOUT = 3'd5;

  // Timer reload values: a phase of N cycles counts N-1 down to 0.
  localparam logic [15:0] MGI_LOAD  = 16'(MGI_CYCLES - 1);
  localparam logic [15:0] RAMP_LOAD = 16'(RAMP_CYCLES - 1);
  // Debounce count at which the next high sample completes qualification.
  localparam logic [7:0]  DEB_LAST  = 8'(DEBOUNCE - 1);

  logic [2:0]  r_state;
  logic [15:0] r_timer;
  logic [7:0]  r_cnt;
  logic [7:0]  r_trip_count;

  logic [2:0]  w_next;
  logic [15:0] w_timer_next;
  logic [7:0]  w_cnt_next;
  logic        w_fire_entry;

  // Next-state, shared timer and debounce counter logic.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    w_next       = r_state;
    w_timer_next = r_timer;
    w_cnt_next   = r_cnt;
    w_fire_entry = 1'b0;

    case (r_state)
      S_SAFE: begin
        // Arming is refused while a trip is present.
        if (i_arm_req && !i_trip_in) w_next = S_ARMED;
      end

      S_ARMED: begin
        if (i_force_trip) begin
          w_fire_entry = 1'b1;
        end else if (i_trip_in) begin
          w_next     = S_QUALIFY;
          w_cnt_next = 8'd1;
        end else if (!i_arm_req) begin
          w_next = S_SAFE;
        end
      end

      S_QUALIFY: begin
        // Disarm is ignored here: an in-progress trip outranks the operator.
        if (i_force_trip) begin
          w_fire_entry = 1'b1;
        end else if (i_trip_in) begin
          if (r_cnt == DEB_LAST) w_fire_entry = 1'b1;
          else                   w_cnt_next   = r_cnt + 8'd1;
        end else begin
          w_next     = S_ARMED;
          w_cnt_next = 8'd0;
        end
      end

      S_FIRE: begin
        if (r_timer == 16'd0) begin
          w_next       = S_RAMP;
          w_timer_next = RAMP_LOAD;
        end else begin
          w_timer_next = r_timer - 16'd1;
        end
      end

      S_RAMP: begin
        if (r_timer == 16'd0) w_next = S_LOCKOUT;
        else                  w_timer_next = r_timer - 16'd1;
      end

      S_LOCKOUT: begin
        // The trip must be gone before an acknowledge is honoured.
        if (i_ack && !i_trip_in) w_next = S_SAFE;
      end

      default: w_next = S_LOCKOUT;  // unused encodings fail safe
    endcase

    if (w_fire_entry) begin
      w_next       = S_FIRE;
      w_timer_next = MGI_LOAD;
      w_cnt_next   = 8'd0;
    end
  end

  // State, timer, counters and registered Moore output decodes.
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (i_rst) begin
      r_state         <= S_SAFE;
      r_timer         <= 16'd0;
      r_cnt           <= 8'd0;
      r_trip_count    <= 8'd0;
      o_armed         <= 1'b0;
      o_mgi_fire      <= 1'b0;
      o_ramp_down     <= 1'b0;
      o_fault_latched <= 1'b0;
    end else begin
      r_state         <= w_next;
      r_timer         <= w_timer_next;
      r_cnt           <= w_cnt_next;
      if (w_fire_entry && (r_trip_count != 8'hFF))
        r_trip_count  <= r_trip_count + 8'd1;
      o_armed         <= (w_next == S_ARMED) || (w_next == S_QUALIFY);
      o_mgi_fire      <= (w_next == S_FIRE);
      o_ramp_down     <= (w_next == S_RAMP);
      o_fault_latched <= (w_next == S_LOCKOUT);
    end
  end

  assign o_state      = r_state;
  assign o_trip_count = r_trip_count;

endmodule

// File: tb/tb_psq_shutdown_sequencer.sv
// tb_psq_shutdown_sequencer
// Scenario tasks plus a randomized run, compared against a phase/age model of
// the shutdown sequence kept in the bench.
module tb_psq_shutdown_sequencer;

  localparam int DEBOUNCE    = 3;
  localparam int MGI_CYCLES  = 16;
  localparam int RAMP_CYCLES = 64;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b0;
  logic       i_arm_req = 1'b0;
  logic       i_trip_in = 1'b0;
  logic       i_force_trip = 1'b0;
  logic       i_ack = 1'b0;
  logic       o_armed;
  logic       o_mgi_fire;
  logic       o_ramp_down;
  logic       o_fault_latched;
  logic [2:0] o_state;
  logic [7:0] o_trip_count;

  int checks   = 0;
  int failures = 0;

  psq_shutdown_sequencer #(
    .DEBOUNCE   (DEBOUNCE),
    .MGI_CYCLES (MGI_CYCLES),
    .RAMP_CYCLES(RAMP_CYCLES)
  ) dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_arm_req      (i_arm_req),
    .i_trip_in      (i_trip_in),
    .i_force_trip   (i_force_trip),
    .i_ack          (i_ack),
    .o_armed        (o_armed),
    .o_mgi_fire     (o_mgi_fire),
    .o_ramp_down    (o_ramp_down),
    .o_fault_latched(o_fault_latched),
    .o_state        (o_state),
    .o_trip_count   (o_trip_count)
  );

  always #5 i_clk = ~i_clk;

  // ---------------- reference model ----------------
  // Phases with an up-counting age / run length rather than a down-timer.
  typedef enum {M_SAFE, M_ARMED, M_QUAL, M_FIRE, M_RAMP, M_LOCK} mode_t;
  mode_t m_mode  = M_SAFE;
  int    m_run   = 0;   // consecutive high trip samples in the current burst
  int    m_age   = 0;   // cycles already spent in FIRE or RAMP
  int    m_trips = 0;

  function automatic void model_fire();
    m_mode  = M_FIRE;
    m_age   = 0;
    m_run   = 0;
    m_trips = (m_trips >= 255) ? 255 : m_trips + 1;
  endfunction

  function automatic void model_edge(bit a, bit t, bit f, bit k, bit r);
    if (r) begin
      m_mode = M_SAFE; m_run = 0; m_age = 0; m_trips = 0;
      return;
    end
    case (m_mode)
      M_SAFE:  if (a && !t) m_mode = M_ARMED;
      M_ARMED: begin
        if (f) model_fire();
        else if (t) begin
          m_run = 1;
          if (m_run >= DEBOUNCE) model_fire(); else m_mode = M_QUAL;
        end else if (!a) m_mode = M_SAFE;
      end
      M_QUAL: begin
        if (f) model_fire();
        else if (t) begin
          m_run++;
          if (m_run >= DEBOUNCE) model_fire();
        end else begin
          m_mode = M_ARMED; m_run = 0;
        end
      end
      M_FIRE: begin
        m_age++;
        if (m_age == MGI_CYCLES) begin m_mode = M_RAMP; m_age = 0; end
      end
      M_RAMP: begin
        m_age++;
        if (m_age == RAMP_CYCLES) begin m_mode = M_LOCK; m_age = 0; end
      end
      M_LOCK:  if (k && !t) m_mode = M_SAFE;
      default: m_mode = M_LOCK;
    endcase
  endfunction

  function automatic logic [14:0] exp_vec();
    logic [2:0] code;
    case (m_mode)
      M_SAFE:  code = 3'd0;
      M_ARMED: code = 3'd1;
      M_QUAL:  code = 3'd2;
      M_FIRE:  code = 3'd3;
      M_RAMP:  code = 3'd4;
      default: code = 3'd5;
    endcase
    return {(m_mode == M_ARMED) || (m_mode == M_QUAL), m_mode == M_FIRE,
            m_mode == M_RAMP, m_mode == M_LOCK, code, 8'(m_trips)};
  endfunction

  function automatic logic [14:0] dut_vec();
    return {o_armed, o_mgi_fire, o_ramp_down, o_fault_latched, o_state, o_trip_count};
  endfunction

  // One clock: apply inputs, advance DUT and model, sample 1 time unit later.
  task automatic tick(input bit a, input bit t, input bit f, input bit k, input bit r);
    i_arm_req = a; i_trip_in = t; i_force_trip = f; i_ack = k; i_rst = r;
    @(posedge i_clk);
    model_edge(a, t, f, k, r);
    #1;
  endtask

  // Idle inputs until LOCKOUT, counting FIRE/RAMP cycles seen on the way.
  task automatic drain(input int max, output int n_mgi, output int n_ramp, output bit ok);
    n_mgi = 0; n_ramp = 0; ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (o_fault_latched === 1'b1) begin ok = 1'b1; break; end
      tick(0, 0, 0, 0, 0);
      if (o_mgi_fire === 1'b1)  n_mgi++;
      if (o_ramp_down === 1'b1) n_ramp++;
    end
    if (o_fault_latched === 1'b1) ok = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    tick(0, 0, 0, 0, 1);
    tick(1, 0, 0, 0, 1);
    checks++;
    if (dut_vec() !== 15'd0) begin
      failures++; $display("FAIL reset_outputs got=%h want=0", dut_vec());
    end
    tick(0, 0, 0, 0, 0);
    checks++;
    if (dut_vec() !== 15'd0 || dut_vec() !== exp_vec()) begin
      failures++; $display("FAIL idle_safe got=%h want=0", dut_vec());
    end
    tick(1, 0, 0, 0, 0);
    checks++;
    if (o_state !== 3'd1 || o_armed !== 1'b1 || dut_vec() !== exp_vec()) begin
      failures++; $display("FAIL arm got state=%0d armed=%b want state=1 armed=1", o_state, o_armed);
    end
  endtask

  task automatic test_debounce();
    bit pat [6] = '{1, 1, 0, 1, 1, 1};
    int n_mgi, n_ramp;
    bit ok;
    for (int i = 0; i < 6; i++) begin
      tick(1, pat[i], 0, 0, 0);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        failures++; $display("FAIL debounce_step%0d got=%h want=%h", i, dut_vec(), exp_vec());
      end
      checks++;
      if (o_mgi_fire !== ((i == 5) ? 1'b1 : 1'b0)) begin
        failures++; $display("FAIL debounce_fire_step%0d got=%b want=%b", i, o_mgi_fire, i == 5);
      end
    end
    drain(200, n_mgi, n_ramp, ok);
    checks++;
    if (!ok || n_mgi + 1 != MGI_CYCLES || n_ramp != RAMP_CYCLES) begin
      failures++;
      $display("FAIL debounce_widths got mgi=%0d ramp=%0d lock=%b want mgi=%0d ramp=%0d lock=1",
               n_mgi + 1, n_ramp, ok, MGI_CYCLES, RAMP_CYCLES);
    end
    checks++;
    if (o_fault_latched !== 1'b1 || o_trip_count !== 8'd1 || dut_vec() !== exp_vec()) begin
      failures++; $display("FAIL debounce_lockout got fault=%b count=%0d want fault=1 count=1",
                           o_fault_latched, o_trip_count);
    end
  endtask

  task automatic test_lockout();
    tick(0, 1, 0, 1, 0);
    checks++;
    if (o_state !== 3'd5 || o_fault_latched !== 1'b1) begin
      failures++; $display("FAIL ack_with_trip got state=%0d want 5", o_state);
    end
    tick(0, 0, 0, 1, 0);
    checks++;
    if (o_state !== 3'd0 || o_fault_latched !== 1'b0 || o_armed !== 1'b0) begin
      failures++; $display("FAIL ack_exit got state=%0d fault=%b want state=0 fault=0", o_state, o_fault_latched);
    end
    tick(1, 1, 0, 0, 0);
    checks++;
    if (o_state !== 3'd0 || o_armed !== 1'b0) begin
      failures++; $display("FAIL arm_refused got state=%0d want 0", o_state);
    end
    tick(1, 0, 0, 0, 0);
    checks++;
    if (o_state !== 3'd1 || dut_vec() !== exp_vec()) begin
      failures++; $display("FAIL rearm got state=%0d want 1", o_state);
    end
  endtask

  task automatic test_force_trip();
    int n_mgi, n_ramp;
    bit ok;
    tick(1, 0, 1, 0, 0);
    checks++;
    if (o_mgi_fire !== 1'b1 || o_state !== 3'd3 || dut_vec() !== exp_vec()) begin
      failures++; $display("FAIL force_fire got mgi=%b state=%0d want mgi=1 state=3", o_mgi_fire, o_state);
    end
    // arm_req held low from here on; the sequence must still complete.
    drain(200, n_mgi, n_ramp, ok);
    checks++;
    if (!ok || n_mgi + 1 != MGI_CYCLES || n_ramp != RAMP_CYCLES || o_trip_count !== 8'd2) begin
      failures++; $display("FAIL force_sequence got mgi=%0d ramp=%0d lock=%b count=%0d",
                           n_mgi + 1, n_ramp, ok, o_trip_count);
    end
  endtask

  task automatic test_reset_mid_fire();
    int n_mgi, n_ramp;
    bit ok;
    tick(0, 0, 0, 1, 0);
    tick(1, 0, 0, 0, 0);
    tick(1, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) tick(1, 0, 0, 0, 0);
    checks++;
    if (o_mgi_fire !== 1'b1) begin
      failures++; $display("FAIL pre_reset_fire got mgi=%b want 1", o_mgi_fire);
    end
    tick(1, 0, 0, 0, 1);
    checks++;
    if (o_state !== 3'd0 || o_mgi_fire !== 1'b0 || o_trip_count !== 8'd0 || dut_vec() !== exp_vec()) begin
      failures++; $display("FAIL reset_mid_fire got state=%0d mgi=%b count=%0d want 0 0 0",
                           o_state, o_mgi_fire, o_trip_count);
    end
    tick(1, 0, 0, 0, 0);
    tick(1, 0, 1, 0, 0);
    drain(200, n_mgi, n_ramp, ok);
    checks++;
    if (!ok || n_mgi + 1 != MGI_CYCLES || n_ramp != RAMP_CYCLES || o_trip_count !== 8'd1) begin
      failures++; $display("FAIL post_reset_timer got mgi=%0d ramp=%0d count=%0d want %0d %0d 1",
                           n_mgi + 1, n_ramp, o_trip_count, MGI_CYCLES, RAMP_CYCLES);
    end
  endtask

  task automatic test_saturation();
    int n_mgi, n_ramp;
    bit ok;
    int stuck = 0;
    for (int i = 0; i < 256; i++) begin
      tick(0, 0, 0, 1, 0);
      tick(1, 0, 0, 0, 0);
      tick(1, 0, 1, 0, 0);
      drain(200, n_mgi, n_ramp, ok);
      if (!ok) stuck++;
    end
    checks++;
    if (stuck != 0) begin
      failures++; $display("FAIL saturation_timeout got stuck=%0d want 0", stuck);
    end
    checks++;
    if (o_trip_count !== 8'd255 || dut_vec() !== exp_vec()) begin
      failures++; $display("FAIL saturation got count=%0d want 255", o_trip_count);
    end
  endtask

  task automatic test_random();
    int errs = 0;
    tick(0, 0, 0, 0, 1);
    for (int i = 0; i < 4000; i++) begin
      bit a, t, f, k, r;
      a = ($urandom_range(9) < 8);
      t = ($urandom_range(9) < 4);
      f = ($urandom_range(99) < 3);
      k = ($urandom_range(9) < 3);
      r = ($urandom_range(999) < 3);
      tick(a, t, f, k, r);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        failures++; errs++;
        if (errs <= 10)
          $display("FAIL random_cycle%0d got=%h want=%h", i, dut_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_lockout();
    test_force_trip();
    test_reset_mid_fire();
    test_saturation();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
